// File: rtl/mem_pattern_checker_if.sv
// mem_pattern_checker_if
//   User-side memory port between a pattern checker (master) and the DDR
//   controller or a responder model (slave).
//   memaddr  : burst base word address
//   memlen   : words per burst minus one
//   memwr    : 1 = write burst, 0 = read burst
//   memreq   : request valid
//   memwdata : write data for the current beat
//   memack   : one pulse per transferred word
//   memrdata : read data, valid in a read-burst ack cycle
interface mem_pattern_checker_if;
  logic [22:0] memaddr;
  logic [1:0]  memlen;
  logic        memwr;
  logic        memreq;
  logic [31:0] memwdata;
  logic        memack;
  logic [31:0] memrdata;

  modport master (
    output memaddr, memlen, memwr, memreq, memwdata,
    input  memack, memrdata
  );

  modport slave (
    input  memaddr, memlen, memwr, memreq, memwdata,
    output memack, memrdata
  );
endinterface

// File: rtl/mem_pattern_checker.sv
// mem_pattern_checker
//   Writes a seed-derived pattern over a word window in fixed-length bursts,
//   reads it back and compares every word. Reports mismatch count, first
//   failing address and a watchdog abort flag.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle pulse, accepted only when idle
//   seed     : pattern seed, captured on accepted start
//   busy     : test in progress
//   done     : one-cycle pulse at test end (normal or abort)
//   errcnt   : mismatching words, saturating
//   erraddr  : first mismatching word address
//   timeout  : last run aborted on the watchdog (sticky until next start)
//   mem      : memory port (master side)
//
// state | meaning
// IDLE  | waiting for start
// WREQ  | write burst requested, counting acks
// WGAP  | one idle cycle after a write burst, advance base
// RREQ  | read burst requested, comparing each acked word
// RGAP  | one idle cycle after a read burst, advance base
// FIN   | done pulse, back to IDLE
module mem_pattern_checker #(
  parameter logic [22:0] BASE    = 23'h000000,
  parameter int          WORDS   = 1024,
  parameter int          BLEN    = 4,
  parameter int          TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic [15:0] errcnt,
  output logic [22:0] erraddr,
  output logic        timeout,
  mem_pattern_checker_if.master mem
);

  localparam logic [1:0]  LAST_BEAT = 2'(BLEN - 1);
  localparam logic [22:0] LAST_BASE = BASE + 23'(WORDS - BLEN);
  localparam logic [22:0] STEP      = 23'(BLEN);
  localparam logic [11:0] WD_LOAD   = 12'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WREQ, WGAP, RREQ, RGAP, FIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] seed_reg;
  logic [31:0] wdata;
  logic [22:0] addr;
  logic [22:0] beat_addr;
  logic [1:0]  beat;
  logic [11:0] wd;
  logic        in_req;
  logic        ack_ok;
  logic        last_beat;
  logic        wd_expire;
  logic        last_burst;

  function automatic logic [31:0] pat(input logic [22:0] a, input logic [31:0] s);
    return {9'b0, a} ^ s;
  endfunction

  assign in_req     = (state == WREQ) || (state == RREQ);
  assign ack_ok     = in_req && mem.memack;
  assign last_beat  = (beat == LAST_BEAT);
  assign wd_expire  = in_req && !mem.memack && (wd == 12'd0);
  assign last_burst = (addr == LAST_BASE);
  assign beat_addr  = addr + {21'b0, beat};

  assign mem.memaddr  = addr;
  assign mem.memlen   = LAST_BEAT;
  assign mem.memwdata = wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    mem.memreq = 1'b0;
    mem.memwr  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = WREQ;
      WREQ: begin
        mem.memreq = 1'b1;
        mem.memwr  = 1'b1;
        if (ack_ok && last_beat) state_nxt = WGAP;
        else if (wd_expire)      state_nxt = FIN;
      end
      WGAP: state_nxt = last_burst ? RREQ : WREQ;
      RREQ: begin
        mem.memreq = 1'b1;
        if (ack_ok && last_beat) state_nxt = RGAP;
        else if (wd_expire)      state_nxt = FIN;
      end
      RGAP: state_nxt = last_burst ? FIN : RREQ;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_reg <= '0;
      wdata    <= '0;
      addr     <= BASE;
      beat     <= '0;
      wd       <= WD_LOAD;
      errcnt   <= '0;
      erraddr  <= '0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            seed_reg <= seed;
            wdata    <= pat(BASE, seed);
            addr     <= BASE;
            beat     <= '0;
            wd       <= WD_LOAD;
            errcnt   <= '0;
            erraddr  <= '0;
            timeout  <= 1'b0;
          end
        end
        WREQ, RREQ: begin
          if (mem.memack) begin
            beat <= last_beat ? 2'd0 : beat + 2'd1;
            wd   <= WD_LOAD;
            // On the last beat this lands on the next burst base's pattern,
            // so a following write burst needs no reload in WGAP.
            if (state == WREQ) wdata <= pat(beat_addr + 23'd1, seed_reg);
            if (state == RREQ && mem.memrdata != pat(beat_addr, seed_reg)) begin
              if (errcnt != 16'hFFFF) errcnt <= errcnt + 16'd1;
              if (errcnt == 16'd0)    erraddr <= beat_addr;
            end
          end else if (wd == 12'd0) begin
            timeout <= 1'b1;
          end else begin
            wd <= wd - 12'd1;
          end
        end
        WGAP: begin
          addr <= last_burst ? BASE : addr + STEP;
          wd   <= WD_LOAD;
        end
        RGAP: begin
          if (!last_burst) addr <= addr + STEP;
          wd <= WD_LOAD;
        end
        FIN: begin
          addr <= BASE;
          beat <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
